eater_ctrl_seq: RTL

- Microcoded control sequencer for the 8-bit bus computer.
- Decodes the instruction-register opcode and carry/zero flags into a 16-bit control word per microstep. That word drives the ALU (EO, SU, FI), the registers, RAM and the program counter.
- Owns the microstep counter and the halt state.
- Sits between the instruction register/flags and every bus-attached block.

---
 rtl/eater_ctrl_seq_if.sv | 21 ++
 rtl/eater_ctrl_seq.sv | 111 +++++++++++
 2 files changed

// File: rtl/eater_ctrl_seq_if.sv
// Sequencer-side bundle: step enable, opcode and flags in; control word and step status out.
interface eater_ctrl_seq_if;
  logic        en;
  logic [3:0]  opcode;
  logic        carry;
  logic        zero;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;
  logic        instr_done;

  modport master (
    output en, opcode, carry, zero,
    input  ctrl, step, halted, instr_done
  );

  modport slave (
    input  en, opcode, carry, zero,
    output ctrl, step, halted, instr_done
  );
endinterface

// File: rtl/eater_ctrl_seq.sv
// Microcoded control sequencer for the 8-bit bus computer: microstep counter,
// halt state and the per-step 16-bit control word (HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI).
module eater_ctrl_seq #(
  parameter bit          EARLY_END = 1'b1,
  parameter int unsigned NSTEPS    = 5
) (
  input  logic            clk,
  input  logic            clr_n,
  eater_ctrl_seq_if.slave bus
);

  typedef enum logic {S_RUN, S_HALT} state_e;

  localparam logic [2:0] LAST_FIXED = 3'(NSTEPS - 1);

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_step, w_step_nxt;
  logic [15:0] w_uword;
  logic [2:0]  w_last;
  logic        w_done;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_RUN;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // Microcode ROM; steps past an opcode's table end read as 0x0000.
  always_comb begin
    w_uword = '0;
    w_last  = 3'd1;
    case (bus.opcode)
      4'h1, 4'h4:                         w_last = 3'd3;
      4'h2, 4'h3:                         w_last = 3'd4;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: w_last = 3'd2;
      default:                            w_last = 3'd1;
    endcase
    case (r_step)
      3'd0: w_uword = 16'h4004;
      3'd1: w_uword = 16'h1408;
      3'd2: begin
        case (bus.opcode)
          4'h1, 4'h2, 4'h3, 4'h4: w_uword = 16'h4800;
          4'h5:                   w_uword = 16'h0A00;
          4'h6:                   w_uword = 16'h0802;
          4'h7:                   w_uword = bus.carry ? 16'h0802 : 16'h0000;
          4'h8:                   w_uword = bus.zero  ? 16'h0802 : 16'h0000;
          4'hE:                   w_uword = 16'h0110;
          4'hF:                   w_uword = 16'h8000;
          default:                w_uword = 16'h0000;
        endcase
      end
      3'd3: begin
        case (bus.opcode)
          4'h1:    w_uword = 16'h1200;
          4'h2:    w_uword = 16'h1020;
          4'h3:    w_uword = 16'h1060;
          4'h4:    w_uword = 16'h2100;
          default: w_uword = 16'h0000;
        endcase
      end
      3'd4: begin
        case (bus.opcode)
          4'h2:    w_uword = 16'h0281;
          4'h3:    w_uword = 16'h02C1;
          default: w_uword = 16'h0000;
        endcase
      end
      default: w_uword = 16'h0000;
    endcase
  end

  assign w_done = EARLY_END ? (r_step == w_last) : (r_step == LAST_FIXED);

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    if (r_state == S_RUN && bus.en) begin
      if (bus.opcode == 4'hF && r_step == 3'd2) begin
        w_state_nxt = S_HALT;
        w_step_nxt  = '0;
      end else if (w_done) begin
        w_step_nxt = '0;
      end else begin
        w_step_nxt = r_step + 3'd1;
      end
    end
  end

  // Reset forces the word low combinationally so no bus driver survives clr_n.
  always_comb begin
    bus.ctrl       = '0;
    bus.instr_done = 1'b0;
    if (clr_n) begin
      if (r_state == S_HALT) begin
        bus.ctrl = 16'h8000;
      end else begin
        bus.ctrl       = w_uword;
        bus.instr_done = w_done;
      end
    end
  end

  assign bus.step   = r_step;
  assign bus.halted = (r_state == S_HALT);

endmodule
